// File: rtl/jp_lift_seq.sv
`default_nettype none
// ============================================================================
// jp_lift_seq : row sequencer feeding jp_process and writing ram_res.
// Rev 1.0 -- optional per-pass skip counter enabled by JP_SKIP_CNT_EN.
// ============================================================================
module jp_lift_seq #(
  parameter int NROWS    = 16,
  parameter int AW       = 10,
  parameter int SW       = 144,
  parameter int FW       = 80,
  parameter int RW       = 10,
  parameter int FLG_ADDR = 0,
  parameter int PROC_LAT = 1
) (
  input  logic          clk_fast,
  input  logic          rst_fast,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] addr_rd,
  input  logic [SW-1:0] dout_lf,
  input  logic [SW-1:0] dout_sa,
  input  logic [SW-1:0] dout_rt,
  output logic [AW-1:0] addr_flgs,
  input  logic [FW-1:0] dout_flgs,
  output logic [SW-1:0] left_s_i,
  output logic [SW-1:0] sam_s_i,
  output logic [SW-1:0] right_s_i,
  output logic [FW-1:0] flgs_s_i,
  output logic          update_s,
  input  logic [RW-1:0] res_out_x,
  input  logic          noupdate_s,
  output logic [AW-1:0] addr_res,
  output logic [RW-1:0] din_res,
`ifdef JP_SKIP_CNT_EN
  output logic [AW:0]   skip_cnt,
`endif
  output logic          we_res
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_UPD   = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_WR    = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  localparam int            CW       = (PROC_LAT > 1) ? $clog2(PROC_LAT) : 1;
  localparam logic [AW-1:0] LAST_ROW = AW'(NROWS - 1);
  localparam logic [AW-1:0] FLG_ROW  = AW'(FLG_ADDR);

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [AW-1:0] row;
  logic [CW-1:0] wait_cnt;
  logic          last_row;
  logic          start_ok;

  assign last_row = (row == LAST_ROW);
  assign start_ok = (state == S_IDLE) && start;

  always_ff @(posedge clk_fast) begin
    if (rst_fast) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // WAIT lasts PROC_LAT cycles: the counter is loaded with PROC_LAT-1 and
  // WAIT exits on the cycle it reads zero.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_FETCH;
      S_FETCH: state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_UPD;
      S_UPD:   state_nxt = S_WAIT;
      S_WAIT:  if (wait_cnt == '0) state_nxt = S_WR;
      S_WR:    state_nxt = last_row ? S_DONE : S_FETCH;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != S_IDLE);
    done      = 1'b0;
    addr_rd   = '0;
    addr_flgs = '0;
    update_s  = 1'b0;
    addr_res  = '0;
    din_res   = '0;
    we_res    = 1'b0;
    case (state)
      S_FETCH: begin
        addr_rd   = row;
        addr_flgs = FLG_ROW;
      end
      S_UPD:   update_s = 1'b1;
      S_WR: begin
        addr_res = row;
        din_res  = res_out_x;
        we_res   = !noupdate_s;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_fast) begin
    if (rst_fast) begin
      row       <= '0;
      wait_cnt  <= '0;
      left_s_i  <= '0;
      sam_s_i   <= '0;
      right_s_i <= '0;
      flgs_s_i  <= '0;
    end else begin
      if (start_ok) begin
        row <= '0;
      end else if ((state == S_WR) && !last_row) begin
        row <= row + AW'(1);
      end
      // Read data for the address issued in FETCH is valid during LOAD.
      if (state == S_LOAD) begin
        left_s_i  <= dout_lf;
        sam_s_i   <= dout_sa;
        right_s_i <= dout_rt;
        flgs_s_i  <= dout_flgs;
      end
      if (state == S_UPD) begin
        wait_cnt <= CW'(PROC_LAT - 1);
      end else if ((state == S_WAIT) && (wait_cnt != '0)) begin
        wait_cnt <= wait_cnt - CW'(1);
      end
    end
  end

`ifdef JP_SKIP_CNT_EN
  localparam int KW = AW + 1;

  always_ff @(posedge clk_fast) begin
    if (rst_fast || start_ok) begin
      skip_cnt <= '0;
    end else if ((state == S_WR) && noupdate_s) begin
      skip_cnt <= skip_cnt + KW'(1);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_jp_lift_seq.sv
`default_nettype none
// tb_jp_lift_seq : directed checks of jp_lift_seq on three parameter sets
// (16 rows / 1 row / 2 rows with PROC_LAT=3 and FLG_ADDR=3).
module tb_jp_lift_seq;

  localparam logic [143:0] SPEC_LF = 144'h1a0d068341a0b088542e0b0581c120905824;
  localparam logic [143:0] SPEC_SA = 144'h160b068341a0b068442a1106824120b05824;
  localparam logic [143:0] SPEC_RT = 144'h160b068341a0d058442a170582c0e090482c;
  localparam logic [79:0]  FLG_BASE = 80'h5a5a_c3c3_0f0f_9696_1234;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;

  logic [143:0] lf_mem [16];
  logic [143:0] sa_mem [16];
  logic [143:0] rt_mem [16];
  logic [79:0]  flg_mem [16];

  // Instance a: 16 rows, b: 1 row, c: 2 rows with 3-cycle processing latency
  logic         a_start = 1'b0, b_start = 1'b0, c_start = 1'b0;
  logic         a_skip_on = 1'b0;
  logic         a_busy, a_done, a_upd, a_we, a_noupd;
  logic         b_busy, b_done, b_upd, b_we, b_noupd;
  logic         c_busy, c_done, c_upd, c_we, c_noupd;
  logic [9:0]   a_ard, a_afl, a_ares, a_din, a_res;
  logic [9:0]   b_ard, b_afl, b_ares, b_din, b_res;
  logic [9:0]   c_ard, c_afl, c_ares, c_din, c_res;
  logic [143:0] a_lf, a_sa, a_rt, a_left, a_sam, a_right;
  logic [143:0] b_lf, b_sa, b_rt, b_left, b_sam, b_right;
  logic [143:0] c_lf, c_sa, c_rt, c_left, c_sam, c_right;
  logic [79:0]  a_flg, a_flgs, b_flg, b_flgs, c_flg, c_flgs;
  logic [1:0]   c_v;
  logic [9:0]   c_d0, c_d1;
`ifdef JP_SKIP_CNT_EN
  logic [10:0]  a_skip, b_skip, c_skip;
`endif

  assign a_noupd = a_skip_on && ((a_ares == 10'd2) || (a_ares == 10'd9));
  assign b_noupd = 1'b0;
  assign c_noupd = 1'b0;

  jp_lift_seq #(.NROWS(16), .PROC_LAT(1)) u_a (
    .clk_fast(clk), .rst_fast(rst), .start(a_start), .busy(a_busy), .done(a_done),
    .addr_rd(a_ard), .dout_lf(a_lf), .dout_sa(a_sa), .dout_rt(a_rt),
    .addr_flgs(a_afl), .dout_flgs(a_flg), .left_s_i(a_left), .sam_s_i(a_sam),
    .right_s_i(a_right), .flgs_s_i(a_flgs), .update_s(a_upd), .res_out_x(a_res),
    .noupdate_s(a_noupd), .addr_res(a_ares), .din_res(a_din),
`ifdef JP_SKIP_CNT_EN
    .skip_cnt(a_skip),
`endif
    .we_res(a_we)
  );

  jp_lift_seq #(.NROWS(1), .PROC_LAT(1)) u_b (
    .clk_fast(clk), .rst_fast(rst), .start(b_start), .busy(b_busy), .done(b_done),
    .addr_rd(b_ard), .dout_lf(b_lf), .dout_sa(b_sa), .dout_rt(b_rt),
    .addr_flgs(b_afl), .dout_flgs(b_flg), .left_s_i(b_left), .sam_s_i(b_sam),
    .right_s_i(b_right), .flgs_s_i(b_flgs), .update_s(b_upd), .res_out_x(b_res),
    .noupdate_s(b_noupd), .addr_res(b_ares), .din_res(b_din),
`ifdef JP_SKIP_CNT_EN
    .skip_cnt(b_skip),
`endif
    .we_res(b_we)
  );

  jp_lift_seq #(.NROWS(2), .PROC_LAT(3), .FLG_ADDR(3)) u_c (
    .clk_fast(clk), .rst_fast(rst), .start(c_start), .busy(c_busy), .done(c_done),
    .addr_rd(c_ard), .dout_lf(c_lf), .dout_sa(c_sa), .dout_rt(c_rt),
    .addr_flgs(c_afl), .dout_flgs(c_flg), .left_s_i(c_left), .sam_s_i(c_sam),
    .right_s_i(c_right), .flgs_s_i(c_flgs), .update_s(c_upd), .res_out_x(c_res),
    .noupdate_s(c_noupd), .addr_res(c_ares), .din_res(c_din),
`ifdef JP_SKIP_CNT_EN
    .skip_cnt(c_skip),
`endif
    .we_res(c_we)
  );

  // Registered-read RAM/ROM models
  always @(posedge clk) begin
    a_lf <= lf_mem[a_ard[3:0]]; a_sa <= sa_mem[a_ard[3:0]];
    a_rt <= rt_mem[a_ard[3:0]]; a_flg <= flg_mem[a_afl[3:0]];
    b_lf <= lf_mem[b_ard[3:0]]; b_sa <= sa_mem[b_ard[3:0]];
    b_rt <= rt_mem[b_ard[3:0]]; b_flg <= flg_mem[b_afl[3:0]];
    c_lf <= lf_mem[c_ard[3:0]]; c_sa <= sa_mem[c_ard[3:0]];
    c_rt <= rt_mem[c_ard[3:0]]; c_flg <= flg_mem[c_afl[3:0]];
  end

  // jp_process stand-ins: result = low bits of left ^ sam ^ flags
  always @(posedge clk) begin
    if (rst) begin
      a_res <= '0; b_res <= '0; c_res <= 10'h3ff;
      c_v <= '0; c_d0 <= '0; c_d1 <= '0;
    end else begin
      if (a_upd) a_res <= a_left[9:0] ^ a_sam[9:0] ^ a_flgs[9:0];
      if (b_upd) b_res <= b_left[9:0] ^ b_sam[9:0] ^ b_flgs[9:0];
      c_v  <= {c_v[0], c_upd};
      c_d0 <= c_left[9:0] ^ c_sam[9:0] ^ c_flgs[9:0];
      c_d1 <= c_d0;
      if (c_v[1]) c_res <= c_d1;
    end
  end

  function automatic logic [9:0] exp_res(input int r, input int fa);
    return lf_mem[r][9:0] ^ sa_mem[r][9:0] ^ flg_mem[fa][9:0];
  endfunction

  function automatic logic a_any_out();
    return a_busy | a_done | a_upd | a_we | (|a_ard) | (|a_afl) | (|a_ares) | (|a_din) |
           (|a_left) | (|a_sam) | (|a_right) | (|a_flgs);
  endfunction

  function automatic logic b_any_out();
    return b_busy | b_done | b_upd | b_we | (|b_ard) | (|b_afl) | (|b_ares) | (|b_din) |
           (|b_left) | (|b_sam) | (|b_right) | (|b_flgs);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int         rec_cnt, rec_done_n, rec_upd;
  int         rec_addr [64];
  int         rec_n [64];
  logic [9:0] rec_dat [64];

  // One pass on instance a; optional stray start pulses and a reset at cycle rst_at.
  task automatic run_a(input int extra1, input int extra2, input int rst_at, input int budget);
    rec_cnt = 0; rec_done_n = -1; rec_upd = 0;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int n = 1; n <= budget; n++) begin
      a_start = (n == extra1) || (n == extra2);
      rst     = (n == rst_at);
      if (a_we && rec_cnt < 64) begin
        rec_addr[rec_cnt] = int'(a_ares);
        rec_dat[rec_cnt]  = a_din;
        rec_n[rec_cnt]    = n;
        rec_cnt++;
      end
      if (a_upd) rec_upd++;
      if (a_done) begin
        rec_done_n = n;
        break;
      end
      tick();
      if (n == rst_at) break;
    end
    a_start = 1'b0;
    rst     = 1'b0;
  endtask

  task automatic test_reset();
    int we_seen, busy_seen;
    rst = 1'b1;
    tick(); tick();
    tests_run++;
    if (a_any_out() !== 1'b0) begin
      tests_failed++; $display("FAIL reset_outs_a: or-of-outputs=%b required 0", a_any_out());
    end
    tests_run++;
    if (b_any_out() !== 1'b0) begin
      tests_failed++; $display("FAIL reset_outs_b: or-of-outputs=%b required 0", b_any_out());
    end
    rst = 1'b0;
    we_seen = 0; busy_seen = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (a_we || b_we || c_we) we_seen++;
      if (a_busy || b_busy || c_busy) busy_seen++;
    end
    tests_run++;
    if (we_seen !== 0) begin
      tests_failed++; $display("FAIL idle_we: we_res cycles=%0d required 0", we_seen);
    end
    tests_run++;
    if (busy_seen !== 0) begin
      tests_failed++; $display("FAIL idle_busy: busy cycles=%0d required 0", busy_seen);
    end
  endtask

  task automatic test_single_row();
    int upd, wr, dn;
    logic [9:0] wa, wd;
    upd = 0; wr = 0; dn = -1; wa = '1; wd = '0;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      if (n == 3) begin
        tests_run++;
        if (b_sam !== SPEC_SA || b_left !== SPEC_LF || b_right !== SPEC_RT) begin
          tests_failed++; $display("FAIL single_capture: sam=%h required %h", b_sam, SPEC_SA);
        end
        tests_run++;
        if (b_flgs !== flg_mem[0]) begin
          tests_failed++; $display("FAIL single_flags: flgs=%h required %h", b_flgs, flg_mem[0]);
        end
      end
      if (b_upd) upd++;
      if (b_we) begin
        wr++; wa = b_ares; wd = b_din;
      end
      if (b_done) begin
        dn = n;
        break;
      end
      tick();
    end
    tests_run++;
    if (upd !== 1) begin
      tests_failed++; $display("FAIL single_update: pulses=%0d required 1", upd);
    end
    tests_run++;
    if (wr !== 1 || wa !== 10'd0) begin
      tests_failed++; $display("FAIL single_write: writes=%0d addr=%0d required 1 at 0", wr, wa);
    end
    tests_run++;
    if (wd !== exp_res(0, 0)) begin
      tests_failed++; $display("FAIL single_din: din=%h required %h", wd, exp_res(0, 0));
    end
    tests_run++;
    if (dn !== 6) begin
      tests_failed++; $display("FAIL single_done: done cycle=%0d required 6", dn);
    end
    tick();
    tests_run++;
    if (b_busy !== 1'b0 || b_done !== 1'b0 || b_sam !== SPEC_SA) begin
      tests_failed++;
      $display("FAIL single_after: busy=%b done=%b sam=%h required 0 0 %h", b_busy, b_done, b_sam, SPEC_SA);
    end
  endtask

  task automatic check_full_pass(input string tag);
    tests_run++;
    if (rec_cnt !== 16) begin
      tests_failed++; $display("FAIL %s_count: writes=%0d required 16", tag, rec_cnt);
    end
    for (int k = 0; k < rec_cnt && k < 16; k++) begin
      tests_run++;
      if (rec_addr[k] !== k || rec_dat[k] !== exp_res(k, 0) || rec_n[k] !== 5 + 5 * k) begin
        tests_failed++;
        $display("FAIL %s_write%0d: addr=%0d din=%h cycle=%0d required %0d %h %0d", tag, k,
                 rec_addr[k], rec_dat[k], rec_n[k], k, exp_res(k, 0), 5 + 5 * k);
      end
    end
    tests_run++;
    if (rec_done_n !== 81) begin
      tests_failed++; $display("FAIL %s_done: done cycle=%0d required 81", tag, rec_done_n);
    end
  endtask

  task automatic test_pass16();
    run_a(0, 0, 0, 120);
    check_full_pass("pass16");
    tests_run++;
    if (rec_upd !== 16) begin
      tests_failed++; $display("FAIL pass16_updates: pulses=%0d required 16", rec_upd);
    end
    tick();
    tests_run++;
    if (a_busy !== 1'b0) begin
      tests_failed++; $display("FAIL pass16_idle: busy=%b required 0", a_busy);
    end
  endtask

  task automatic test_start_while_busy();
    run_a(17, 37, 0, 120);
    check_full_pass("restart");
    tick();
  endtask

  task automatic test_reset_mid_pass();
    int seen;
    run_a(0, 0, 27, 120);
    tests_run++;
    if (rec_cnt !== 5) begin
      tests_failed++; $display("FAIL midrst_writes: writes=%0d required 5", rec_cnt);
    end
    tests_run++;
    if (a_any_out() !== 1'b0) begin
      tests_failed++; $display("FAIL midrst_outs: or-of-outputs=%b required 0", a_any_out());
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (a_we || a_done || a_busy) seen++;
      tick();
    end
    tests_run++;
    if (seen !== 0) begin
      tests_failed++; $display("FAIL midrst_quiet: active cycles=%0d required 0", seen);
    end
    run_a(0, 0, 0, 120);
    check_full_pass("midrst_rerun");
    tick();
  endtask

  task automatic test_skip_rows();
    int idx;
    a_skip_on = 1'b1;
    run_a(0, 0, 0, 120);
    a_skip_on = 1'b0;
    tests_run++;
    if (rec_cnt !== 14) begin
      tests_failed++; $display("FAIL skip_count: writes=%0d required 14", rec_cnt);
    end
    idx = 0;
    for (int r = 0; r < 16; r++) begin
      if (r != 2 && r != 9 && idx < rec_cnt) begin
        tests_run++;
        if (rec_addr[idx] !== r || rec_dat[idx] !== exp_res(r, 0)) begin
          tests_failed++;
          $display("FAIL skip_write%0d: addr=%0d din=%h required %0d %h", idx, rec_addr[idx],
                   rec_dat[idx], r, exp_res(r, 0));
        end
        idx++;
      end
    end
    tests_run++;
    if (rec_done_n !== 81) begin
      tests_failed++; $display("FAIL skip_done: done cycle=%0d required 81", rec_done_n);
    end
`ifdef JP_SKIP_CNT_EN
    tick(); tick(); tick();
    tests_run++;
    if (a_skip !== 11'd2) begin
      tests_failed++; $display("FAIL skip_cnt: skip_cnt=%0d required 2", a_skip);
    end
`endif
    tick();
  endtask

  task automatic test_back_to_back();
    run_a(0, 0, 0, 120);
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    tests_run++;
    if (a_busy !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_done_start: busy=%b required 0", a_busy);
    end
    tick();
    tests_run++;
    if (a_busy !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_not_queued: busy=%b required 0", a_busy);
    end
    run_a(0, 0, 0, 120);
    check_full_pass("b2b");
`ifdef JP_SKIP_CNT_EN
    tests_run++;
    if (a_skip !== 11'd0) begin
      tests_failed++; $display("FAIL b2b_skip_cleared: skip_cnt=%0d required 0", a_skip);
    end
`endif
    tick();
  endtask

  task automatic test_start_with_reset();
    rst = 1'b1; a_start = 1'b1;
    tick();
    rst = 1'b0; a_start = 1'b0;
    tests_run++;
    if (a_busy !== 1'b0) begin
      tests_failed++; $display("FAIL rst_start: busy=%b required 0", a_busy);
    end
    tick();
    tests_run++;
    if (a_busy !== 1'b0) begin
      tests_failed++; $display("FAIL rst_start_later: busy=%b required 0", a_busy);
    end
  endtask

  task automatic test_proc_lat();
    int wr, dn, upd;
    int wn [2];
    int wa [2];
    logic [9:0] wd [2];
    wr = 0; dn = -1; upd = 0;
    wn[0] = -1; wn[1] = -1; wa[0] = -1; wa[1] = -1; wd[0] = '0; wd[1] = '0;
    c_start = 1'b1;
    tick();
    c_start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (c_upd) upd++;
      if (c_we) begin
        if (wr < 2) begin
          wn[wr] = n; wa[wr] = int'(c_ares); wd[wr] = c_din;
        end
        wr++;
      end
      if (c_done) begin
        dn = n;
        break;
      end
      tick();
    end
    tests_run++;
    if (wr !== 2 || upd !== 2) begin
      tests_failed++; $display("FAIL lat3_count: writes=%0d updates=%0d required 2 2", wr, upd);
    end
    tests_run++;
    if (wa[0] !== 0 || wn[0] !== 7 || wd[0] !== exp_res(0, 3)) begin
      tests_failed++;
      $display("FAIL lat3_row0: addr=%0d cycle=%0d din=%h required 0 7 %h", wa[0], wn[0], wd[0], exp_res(0, 3));
    end
    tests_run++;
    if (wa[1] !== 1 || wn[1] !== 14 || wd[1] !== exp_res(1, 3)) begin
      tests_failed++;
      $display("FAIL lat3_row1: addr=%0d cycle=%0d din=%h required 1 14 %h", wa[1], wn[1], wd[1], exp_res(1, 3));
    end
    tests_run++;
    if (dn !== 15) begin
      tests_failed++; $display("FAIL lat3_done: done cycle=%0d required 15", dn);
    end
    tick();
  endtask

  initial begin
    for (int r = 0; r < 16; r++) begin
      lf_mem[r]  = SPEC_LF ^ (144'(r) << 3);
      sa_mem[r]  = SPEC_SA ^ (144'(r) * 144'h41);
      rt_mem[r]  = SPEC_RT ^ (144'(r) << 120);
      flg_mem[r] = FLG_BASE ^ (80'(r) * 80'h105);
    end
    test_reset();
    test_single_row();
    test_pass16();
    test_start_while_busy();
    test_reset_mid_pass();
    test_skip_rows();
    test_back_to_back();
    test_start_with_reset();
    test_proc_lat();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
